// File: rtl/bus_master_ctrl_pkg.sv
// Shared constants for bus_master_ctrl: FSM encodings, bus direction values,
// error-data pattern and counter widths.
package bus_master_ctrl_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_STROBE = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    localparam logic DIR_WRITE = 1'b1;
    localparam logic DIR_READ  = 1'b0;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned WAIT_CNT_W = 4;
    localparam int unsigned TO_CNT_W   = 8;

    localparam logic [DATA_W-1:0] ERR_DATA = 8'hFF;

endpackage

// File: rtl/bus_master_ctrl_wait_counter.sv
// bus_wait_counter: loadable down-counter with a zero flag, used for strobe
// wait states and for the bus_wait timeout window.
module bus_wait_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero_c
);

    logic [W-1:0] r_count;

    // Load wins over decrement; decrement saturates at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_zero_c = (r_count == '0);

endmodule

// File: rtl/bus_master_ctrl.sv
// bus_master_ctrl: runs read/write cycles on the shared 8-bit data bus.
// Optional macro BUS_TIMEOUT_EN adds bus_wait stall handling and resp_err.
module bus_master_ctrl
    import bus_master_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned WAIT_CYCLES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_wdata,
    output logic              resp_valid,
    output logic [7:0]        resp_rdata,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [7:0]        bus_dout,
    input  logic [7:0]        bus_din,
    output logic              bus_dir,
    output logic              bus_rd_n,
    output logic              bus_wr_n
`ifdef BUS_TIMEOUT_EN
    ,
    input  logic              bus_wait,
    output logic              resp_err
`endif
);

    if (WAIT_CYCLES > 15 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
        $error("bus_master_ctrl: WAIT_CYCLES or TIMEOUT_CYCLES out of range");
    end

    logic [1:0]        r_state;
    logic              r_we;

    logic [1:0]        w_state_nxt;
    logic              w_we_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [7:0]        w_dout_nxt;
    logic              w_dir_nxt;
    logic              w_rd_n_nxt;
    logic              w_wr_n_nxt;
    logic              w_resp_valid_nxt;
    logic [7:0]        w_rdata_nxt;
    logic              w_leave;
    logic              w_wcnt_load;
    logic              w_wcnt_dec;
    logic              w_wcnt_zero;

`ifdef BUS_TIMEOUT_EN
    logic r_ext;
    logic r_err_pend;
    logic w_ext_nxt;
    logic w_err_pend_nxt;
    logic w_resp_err_nxt;
    logic w_timeout;
    logic w_tcnt_load;
    logic w_tcnt_dec;
    logic w_tcnt_zero;
`endif

    assign req_ready = (r_state == ST_IDLE) && !rst;

    bus_wait_counter #(.W(WAIT_CNT_W)) u_wait_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_wcnt_load),
        .i_load_val (WAIT_CNT_W'(WAIT_CYCLES)),
        .i_dec      (w_wcnt_dec),
        .o_zero_c   (w_wcnt_zero)
    );

`ifdef BUS_TIMEOUT_EN
    // Loaded with limit-1 so exactly TIMEOUT_CYCLES extension cycles are granted.
    bus_wait_counter #(.W(TO_CNT_W)) u_timeout_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tcnt_load),
        .i_load_val (TO_CNT_W'(TIMEOUT_CYCLES - 1)),
        .i_dec      (w_tcnt_dec),
        .o_zero_c   (w_tcnt_zero)
    );
`endif

    // Next-state and next-output logic; every registered output is computed here.
    always_comb begin
        w_state_nxt      = r_state;
        w_we_nxt         = r_we;
        w_addr_nxt       = bus_addr;
        w_dout_nxt       = bus_dout;
        w_dir_nxt        = bus_dir;
        w_rd_n_nxt       = 1'b1;
        w_wr_n_nxt       = 1'b1;
        w_resp_valid_nxt = 1'b0;
        w_rdata_nxt      = resp_rdata;
        w_leave          = 1'b0;
        w_wcnt_load      = 1'b0;
        w_wcnt_dec       = 1'b0;
`ifdef BUS_TIMEOUT_EN
        w_ext_nxt        = r_ext;
        w_err_pend_nxt   = r_err_pend;
        w_resp_err_nxt   = 1'b0;
        w_timeout        = 1'b0;
        w_tcnt_load      = 1'b0;
        w_tcnt_dec       = 1'b0;
`endif

        case (r_state)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    w_we_nxt    = req_we;
                    w_addr_nxt  = req_addr;
                    w_dir_nxt   = req_we ? DIR_WRITE : DIR_READ;
                    if (req_we) begin
                        w_dout_nxt = req_wdata;
                    end
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_wcnt_load = 1'b1;
                w_rd_n_nxt  = r_we;
                w_wr_n_nxt  = !r_we;
                w_state_nxt = ST_STROBE;
`ifdef BUS_TIMEOUT_EN
                w_ext_nxt      = 1'b0;
                w_err_pend_nxt = 1'b0;
`endif
            end
            ST_STROBE: begin
                w_rd_n_nxt = r_we;
                w_wr_n_nxt = !r_we;
`ifdef BUS_TIMEOUT_EN
                if (!r_ext) begin
                    if (!w_wcnt_zero) begin
                        w_wcnt_dec = 1'b1;
                    end else if (bus_wait) begin
                        w_tcnt_load = 1'b1;
                        w_ext_nxt   = 1'b1;
                    end else begin
                        w_leave = 1'b1;
                    end
                end else if (!bus_wait) begin
                    w_leave = 1'b1;
                end else if (w_tcnt_zero) begin
                    w_leave   = 1'b1;
                    w_timeout = 1'b1;
                end else begin
                    w_tcnt_dec = 1'b1;
                end
`else
                if (w_wcnt_zero) begin
                    w_leave = 1'b1;
                end else begin
                    w_wcnt_dec = 1'b1;
                end
`endif
                // Last strobe cycle: release strobes and capture read data.
                if (w_leave) begin
                    w_state_nxt = ST_HOLD;
                    w_rd_n_nxt  = 1'b1;
                    w_wr_n_nxt  = 1'b1;
                    if (!r_we) begin
                        w_rdata_nxt = bus_din;
                    end
`ifdef BUS_TIMEOUT_EN
                    if (w_timeout) begin
                        w_rdata_nxt    = ERR_DATA;
                        w_err_pend_nxt = 1'b1;
                    end
`endif
                end
            end
            ST_HOLD: begin
                w_state_nxt      = ST_IDLE;
                w_resp_valid_nxt = 1'b1;
                w_dir_nxt        = DIR_READ;
`ifdef BUS_TIMEOUT_EN
                w_resp_err_nxt   = r_err_pend;
                w_err_pend_nxt   = 1'b0;
`endif
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_we       <= 1'b0;
            bus_addr   <= '0;
            bus_dout   <= '0;
            bus_dir    <= DIR_READ;
            bus_rd_n   <= 1'b1;
            bus_wr_n   <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
`ifdef BUS_TIMEOUT_EN
            r_ext      <= 1'b0;
            r_err_pend <= 1'b0;
            resp_err   <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_we       <= w_we_nxt;
            bus_addr   <= w_addr_nxt;
            bus_dout   <= w_dout_nxt;
            bus_dir    <= w_dir_nxt;
            bus_rd_n   <= w_rd_n_nxt;
            bus_wr_n   <= w_wr_n_nxt;
            resp_valid <= w_resp_valid_nxt;
            resp_rdata <= w_rdata_nxt;
`ifdef BUS_TIMEOUT_EN
            r_ext      <= w_ext_nxt;
            r_err_pend <= w_err_pend_nxt;
            resp_err   <= w_resp_err_nxt;
`endif
        end
    end

endmodule
